imem_port_arbiter: RTL

Two-port arbiter that shares the single combinational read port of the instruction memory between the fetch stage and the data-side load path. Code-space loads and constant pools are served through this port. It accepts one request per cycle and grants round-robin on conflict. It drives the memory address combinationally and returns registered read data and an error flag to the granted requester one cycle later. It sits between the IF stage / MEM stage and the instruction memory, and also keeps a saturating conflict counter for performance monitoring.

---
 rtl/imem_port_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing the instruction memory read port between fetch and
// data-side loads, with registered responses and a saturating conflict counter.
module imem_port_arbiter #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        f_flush,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_raddr,
    output logic        mem_ren,
    input  logic [31:0] mem_dout,
    output logic [31:0] conflict_cnt
);

    localparam logic [29:0] WORDS = 30'(DEPTH);

    logic fq;
    logic dq;
    logic gnt_any;
    logic err_now;
    logic last_gnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Arbitration and address select: last_gnt=1 means data won last, so fetch wins a tie
    always_comb begin
        fq        = f_req & ~f_flush & ~rst;
        dq        = d_req & ~rst;
        f_gnt     = fq & (~dq | last_gnt);
        d_gnt     = dq & ~f_gnt;
        gnt_any   = f_gnt | d_gnt;
        mem_raddr = d_gnt ? d_addr : f_addr;
        err_now   = (mem_raddr[1:0] != 2'b00) | (mem_raddr[31:2] >= WORDS);
        mem_ren   = gnt_any & ~err_now;
    end

    // Response stage: one-cycle pulse to the granted port, rdata held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            f_rvalid     <= 1'b0;
            f_err        <= 1'b0;
            f_rdata      <= '0;
            d_rvalid     <= 1'b0;
            d_err        <= 1'b0;
            d_rdata      <= '0;
            last_gnt     <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            f_rvalid <= f_gnt;
            f_err    <= f_gnt & err_now;
            d_rvalid <= d_gnt;
            d_err    <= d_gnt & err_now;
            if (f_gnt)
                f_rdata <= err_now ? 32'd0 : mem_dout;
            if (d_gnt)
                d_rdata <= err_now ? 32'd0 : mem_dout;
            if (gnt_any)
                last_gnt <= d_gnt;
            if (fq & dq)
                conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

endmodule
